// File: rtl/disp_window_line_buffer.sv
// Disparity window line buffer: emits a vertical column of NUM_LINE+1 pixels
// per enabled cycle, with masked borders, padding rows and frame tracking.
module disp_window_line_buffer #(
    parameter int WIDTH    = 16,
    parameter int NUM_LINE = 4,
    parameter int AWIDTH   = 11,
    parameter int DEPTH    = 1920,
    parameter int HWIDTH   = 11
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clken,
    input  logic                          sof,
    input  logic                          pad_in,
    input  logic [AWIDTH-1:0]             img_width,
    input  logic [HWIDTH-1:0]             img_height,
    input  logic                          win_mode,
    input  logic [WIDTH-1:0]              data_in,
    output logic [WIDTH*(NUM_LINE+1)-1:0] data_out,
    output logic                          valid,
    output logic                          eol,
    output logic                          frame_done
);

    localparam int MW  = WIDTH * NUM_LINE;
    localparam int OW  = MW + WIDTH;
    localparam int CTR = NUM_LINE / 2;

    logic [MW-1:0]       mem_q [DEPTH];

    logic [AWIDTH-1:0]   col_q, col_d, col_eff;
    logic                row_pad_q, row_pad_eff;
    logic [NUM_LINE-1:0] mask_q, mask_d, mask_eff;
    logic [HWIDTH-1:0]   out_row_q, out_row_d, out_row_eff;
    logic                done_q, done_d, done_eff;
    logic [OW-1:0]       data_q, data_d;
    logic                valid_q, valid_d;
    logic                eol_q, eol_d;
    logic                fd_q, fd_d;

    logic [MW-1:0]       rd, masked, wr_word;
    logic [WIDTH-1:0]    din;
    logic [31:0]         width_c;

    always_comb begin
        if (img_width == '0) begin
            width_c = 32'd1;
        end else if (32'(img_width) > 32'(DEPTH)) begin
            width_c = 32'(DEPTH);
        end else begin
            width_c = 32'(img_width);
        end
    end

    // sof restarts the frame on the very pixel it accompanies
    always_comb begin
        col_eff     = sof ? '0 : col_q;
        mask_eff    = sof ? '0 : mask_q;
        out_row_eff = sof ? '0 : out_row_q;
        done_eff    = sof ? 1'b0 : done_q;
        row_pad_eff = (col_eff == '0) ? pad_in : row_pad_q;
        din         = row_pad_eff ? '0 : data_in;
        rd          = mem_q[col_eff];

        masked = '0;
        for (int i = 0; i < NUM_LINE; i++) begin
            if (mask_eff[i]) begin
                masked[i*WIDTH +: WIDTH] = rd[i*WIDTH +: WIDTH];
            end
        end

        wr_word = {din, rd[MW-1:WIDTH]};
        eol_d   = (32'(col_eff) == width_c - 32'd1);

        data_d = '0;
        if (win_mode) begin
            data_d[OW-1 -: 3*WIDTH] = {din, masked[MW-1 -: 2*WIDTH]};
            valid_d = mask_eff[NUM_LINE-1];
        end else begin
            data_d  = {din, masked};
            valid_d = mask_eff[CTR];
        end

        fd_d = valid_d & eol_d & ~done_eff &
               (out_row_eff == img_height - HWIDTH'(1));

        col_d  = eol_d ? '0 : col_eff + AWIDTH'(1);
        mask_d = eol_d ? {~row_pad_eff, mask_eff[NUM_LINE-1:1]} : mask_eff;

        out_row_d = out_row_eff;
        done_d    = done_eff;
        if (eol_d && valid_d) begin
            if (fd_d) begin
                done_d = 1'b1;
            end else if (!done_eff) begin
                out_row_d = out_row_eff + HWIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q     <= '0;
            row_pad_q <= 1'b0;
            mask_q    <= '0;
            out_row_q <= '0;
            done_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            eol_q     <= 1'b0;
            fd_q      <= 1'b0;
        end else if (clken) begin
            col_q     <= col_d;
            row_pad_q <= row_pad_eff;
            mask_q    <= mask_d;
            out_row_q <= out_row_d;
            done_q    <= done_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            eol_q     <= eol_d;
            fd_q      <= fd_d;
        end else begin
            fd_q      <= 1'b0;
        end
    end

    // Line storage is intentionally not reset; the mask hides stale words
    always_ff @(posedge clk) begin
        if (clken) begin
            mem_q[col_eff] <= wr_word;
        end
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign eol        = eol_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_disp_window_line_buffer.sv
// Bench for disp_window_line_buffer: directed vector table, corner sequences
// and randomized frames against a row-history reference model.
module tb_disp_window_line_buffer;

    localparam int W    = 16;
    localparam int NL   = 4;
    localparam int OW   = W * (NL + 1);
    localparam int AW   = 11;
    localparam int DP   = 1920;
    localparam int HW   = 11;
    localparam int NTBL = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clken = 1'b0;
    logic          sof = 1'b0;
    logic          pad_in = 1'b0;
    logic          win_mode = 1'b0;
    logic [AW-1:0] img_width = '0;
    logic [HW-1:0] img_height = '0;
    logic [W-1:0]  data_in = '0;
    logic [OW-1:0] data_out;
    logic          valid, eol, frame_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    disp_window_line_buffer #(
        .WIDTH(W), .NUM_LINE(NL), .AWIDTH(AW), .DEPTH(DP), .HWIDTH(HW)
    ) dut (
        .clk(clk), .rst(rst), .clken(clken), .sof(sof), .pad_in(pad_in),
        .img_width(img_width), .img_height(img_height), .win_mode(win_mode),
        .data_in(data_in), .data_out(data_out), .valid(valid), .eol(eol),
        .frame_done(frame_done)
    );

    // Reference: per-frame row history; row r of the frame lives in slot r%16
    logic [W-1:0]  hist [16][DP];
    bit            isimg [16];
    int            mr, mc, orow;
    bit            mdone, mpad;
    logic [OW-1:0] last_d;
    logic          last_v, last_e;

    typedef struct {
        int            scen;
        int            k;
        logic [OW-1:0] dout;
        logic          v;
        logic          e;
        logic          f;
    } vec_t;
    vec_t tbl [NTBL];

    function automatic void model_reset();
        mr = 0; mc = 0; orow = 0; mdone = 1'b0; mpad = 1'b0;
        last_d = '0; last_v = 1'b0; last_e = 1'b0;
    endfunction

    task automatic model_step(input bit s, input bit p, input logic [W-1:0] d,
                              input bit wm, input int width, input int height,
                              output logic [OW-1:0] ed, output logic ev,
                              output logic ee, output logic ef);
        int wcl, row, crow;
        logic [W-1:0] dv;
        if (s) begin
            mr = 0; mc = 0; orow = 0; mdone = 1'b0;
        end
        if (mc == 0) mpad = p;
        wcl = (width < 1) ? 1 : ((width > DP) ? DP : width);
        dv = mpad ? '0 : d;
        ed = '0;
        ed[OW-1 -: W] = dv;
        for (int i = 0; i < NL; i++) begin
            row = mr - NL + i;
            if (!(wm && i < NL - 2) && row >= 0) begin
                if (isimg[row % 16]) ed[i*W +: W] = hist[row % 16][mc];
            end
        end
        crow = mr - (wm ? 1 : NL / 2);
        ev = 1'b0;
        if (crow >= 0) ev = isimg[crow % 16];
        ee = (mc == wcl - 1);
        ef = ev && ee && (orow == height - 1) && !mdone;
        hist[mr % 16][mc] = dv;
        isimg[mr % 16] = !mpad;
        if (ee) begin
            if (ev) begin
                if (ef) mdone = 1'b1;
                else if (!mdone) orow++;
            end
            mr++;
            mc = 0;
        end else begin
            mc++;
        end
    endtask

    task automatic check(input string tag, input logic [OW-1:0] ed,
                         input logic ev, input logic ee, input logic ef);
        checks++;
        if (data_out !== ed || valid !== ev || eol !== ee || frame_done !== ef) begin
            failures++;
            $display("FAIL %s: got data=%h v=%b e=%b fd=%b, expected data=%h v=%b e=%b fd=%b",
                     tag, data_out, valid, eol, frame_done, ed, ev, ee, ef);
        end
    endtask

    task automatic px(input bit s, input bit p, input logic [W-1:0] d, input string tag);
        logic [OW-1:0] ed;
        logic ev, ee, ef;
        sof = s; pad_in = p; data_in = d; clken = 1'b1;
        model_step(s, p, d, win_mode, int'(img_width), int'(img_height), ed, ev, ee, ef);
        @(posedge clk);
        #1;
        check(tag, ed, ev, ee, ef);
        last_d = ed; last_v = ev; last_e = ee;
        clken = 1'b0; sof = 1'b0;
    endtask

    task automatic idle();
        clken = 1'b0;
        data_in = W'($urandom);
        @(posedge clk);
        #1;
        check("hold", last_d, last_v, last_e, 1'b0);
    endtask

    // gap_row: -1 none, -2 random gaps, else gap after every pixel of that row
    task automatic run_frame(input bit wm, input int w, input int h, input int npad,
                             input int scen, input int gap_row, input int stop_row,
                             input int stop_col, input bit rnd);
        int wc, k;
        logic [W-1:0] d;
        win_mode = wm;
        img_width = AW'(w);
        img_height = HW'(h);
        wc = (w < 1) ? 1 : ((w > DP) ? DP : w);
        k = 0;
        for (int r = 0; r < h + npad; r++) begin
            for (int c = 0; c < wc; c++) begin
                if (r == stop_row && c == stop_col) return;
                d = rnd ? W'($urandom) : W'(16 * r + c);
                px(r == 0 && c == 0, r >= h, d,
                   $sformatf("s%0d_m%0d_w%0d_r%0d_c%0d", scen, wm, w, r, c));
                for (int j = 0; j < NTBL; j++) begin
                    if (tbl[j].scen == scen && tbl[j].k == k) begin
                        checks++;
                        if (data_out !== tbl[j].dout || valid !== tbl[j].v ||
                            eol !== tbl[j].e || frame_done !== tbl[j].f) begin
                            failures++;
                            $display("FAIL tbl%0d k=%0d: got data=%h v=%b e=%b fd=%b, expected data=%h v=%b e=%b fd=%b",
                                     j, k, data_out, valid, eol, frame_done,
                                     tbl[j].dout, tbl[j].v, tbl[j].e, tbl[j].f);
                        end
                    end
                end
                if (r == gap_row || (gap_row == -2 && $urandom_range(0, 3) == 0)) idle();
                k++;
            end
        end
    endtask

    initial begin
        int wm, w, h, sr, sc;

        tbl[0] = '{0,  0, {80'h0}, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{0,  3, {16'h0003, 64'h0}, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{0,  5, {16'h0011, 16'h0001, 48'h0}, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{0,  8, {16'h0020, 16'h0010, 16'h0000, 32'h0}, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{0, 11, {16'h0023, 16'h0013, 16'h0003, 32'h0}, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{0, 14, {16'h0000, 16'h0022, 16'h0012, 16'h0002, 16'h0000}, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{0, 19, {32'h0, 16'h0023, 16'h0013, 16'h0003}, 1'b1, 1'b1, 1'b1};
        tbl[7] = '{1,  6, {16'h0012, 16'h0002, 48'h0}, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{1, 15, {16'h0000, 16'h0023, 16'h0013, 32'h0}, 1'b1, 1'b1, 1'b1};

        model_reset();
        #22;
        check("reset", '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        run_frame(1'b0, 4, 3, 2, 0, -1, -1, -1, 1'b0);
        run_frame(1'b1, 4, 3, 1, 1, -1, -1, -1, 1'b0);
        run_frame(1'b0, 4, 3, 2, 0, 1, -1, -1, 1'b0);

        run_frame(1'b0, 4, 3, 2, -1, -1, 2, 1, 1'b0);
        run_frame(1'b0, 4, 3, 2, -1, -1, -1, -1, 1'b1);

        run_frame(1'b0, 1, 3, 2, -1, -1, -1, -1, 1'b1);
        run_frame(1'b1, DP, 2, 1, -1, -1, -1, -1, 1'b1);
        run_frame(1'b1, DP + 5, 1, 1, -1, -1, -1, -1, 1'b1);

        run_frame(1'b0, 4, 3, 2, -1, -1, 1, 2, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", '0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("rst_hold", '0, 1'b0, 1'b0, 1'b0);
        #3;
        rst = 1'b0;
        model_reset();
        run_frame(1'b0, 4, 3, 2, 0, -1, -1, -1, 1'b0);

        for (int f = 0; f < 10; f++) begin
            wm = $urandom_range(0, 1);
            w  = $urandom_range(1, 6);
            h  = $urandom_range(1, 4);
            sr = -1;
            sc = -1;
            if ($urandom_range(0, 3) == 0) begin
                sr = $urandom_range(0, h);
                sc = $urandom_range(0, w - 1);
            end
            run_frame(wm[0], w, h, wm[0] ? 1 : NL / 2, -1, -2, sr, sc, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
